// File: rtl/usb_bit_pkg.sv
// Shared definitions for the USB bit stuffer / unstuffer pair.
package usb_bit_pkg;

  localparam int USB_MAX_ONES = 6;

  typedef enum logic [1:0] {
    NORMAL       = 2'd0,
    EXPECT_STUFF = 2'd1,
    ERROR        = 2'd2
  } unstuff_state_t;

endpackage

// File: rtl/usb_ones_counter.sv
// Saturating run counter of consecutive 1s; a clear with inc in the same
// cycle restarts the run at 1 (the incoming bit starts a fresh run).
module usb_ones_counter #(
  parameter int MAX = 6,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  logic [CW-1:0] cnt_d;

  assign at_max = (cnt == CW'(MAX));

  always_comb begin
    cnt_d = cnt;
    if (clear) begin
      cnt_d = inc ? CW'(1) : '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_bit_unstuffer.sv
// RX bit unstuffer: drops the stuffed 0 after MAX_ONES 1s, flags a sticky
// stuff error on MAX_ONES+1 1s. All outputs registered, 1-cycle latency.
module usb_bit_unstuffer
  import usb_bit_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES,
  localparam int CW = $clog2(MAX_ONES + 1)
) (
  input  logic           clk,
  input  logic           nRST,
  input  logic           in_bit,
  input  logic           in_valid,
  input  logic           pkt_start,
  output logic           out_bit,
  output logic           out_valid,
  output logic           stuff_drop,
  output logic           stuff_err,
  output unstuff_state_t dbg_state,
  output logic [CW-1:0]  dbg_ones_cnt
);

  // Stream semantics: in_valid qualifies in_bit for exactly one cycle (no
  // backpressure); out_valid qualifies out_bit for exactly one cycle.

  unstuff_state_t state_q, state_d;
  logic [CW-1:0]  ones_cnt;
  logic           ones_at_max;
  logic           cnt_clear, cnt_inc;
  logic           out_bit_d, out_valid_d, drop_d, err_d;
  unstuff_state_t eff_state;
  logic [CW-1:0]  eff_cnt;

  usb_ones_counter #(.MAX(MAX_ONES)) u_ones_counter (
    .clk    (clk),
    .nRST   (nRST),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .cnt    (ones_cnt),
    .at_max (ones_at_max)
  );

  // pkt_start restarts the packet before the same-cycle bit is interpreted.
  assign eff_state = pkt_start ? NORMAL : state_q;
  assign eff_cnt   = pkt_start ? '0 : ones_cnt;

  always_comb begin
    state_d     = state_q;
    cnt_clear   = pkt_start;
    cnt_inc     = 1'b0;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    drop_d      = 1'b0;
    err_d       = pkt_start ? 1'b0 : stuff_err;
    if (pkt_start) begin
      state_d = NORMAL;
    end
    if (in_valid) begin
      case (eff_state)
        NORMAL: begin
          out_valid_d = 1'b1;
          out_bit_d   = in_bit;
          if (!in_bit) begin
            cnt_clear = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            if (eff_cnt == CW'(MAX_ONES - 1)) begin
              state_d = EXPECT_STUFF;
            end
          end
        end
        EXPECT_STUFF: begin
          if (!in_bit) begin
            drop_d    = 1'b1;
            cnt_clear = 1'b1;
            state_d   = NORMAL;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
        default: begin
          state_d = eff_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= NORMAL;
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      stuff_drop <= 1'b0;
      stuff_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_bit    <= out_bit_d;
      out_valid  <= out_valid_d;
      stuff_drop <= drop_d;
      stuff_err  <= err_d;
    end
  end

  assign dbg_state    = state_q;
  assign dbg_ones_cnt = ones_cnt;

  logic unused_at_max;
  assign unused_at_max = ones_at_max;

endmodule

// File: tb/tb_usb_bit_unstuffer.sv
// Bench for usb_bit_unstuffer: directed cases plus random traffic checked
// against a run-length model of USB bit unstuffing.
module tb_usb_bit_unstuffer;
  import usb_bit_pkg::*;

  localparam int MAX = 6;

  logic           clk = 1'b0;
  logic           nRST = 1'b0;
  logic           in_bit = 1'b0;
  logic           in_valid = 1'b0;
  logic           pkt_start = 1'b0;
  logic           out_bit, out_valid, stuff_drop, stuff_err;
  unstuff_state_t dbg_state;
  logic [2:0]     dbg_ones_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  int   m_run = 0;
  bit   m_err = 0;
  logic exp_q[$];
  int   seg_valid = 0;
  int   seg_drop = 0;

  usb_bit_unstuffer #(.MAX_ONES(MAX)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .in_bit       (in_bit),
    .in_valid     (in_valid),
    .pkt_start    (pkt_start),
    .out_bit      (out_bit),
    .out_valid    (out_valid),
    .stuff_drop   (stuff_drop),
    .stuff_err    (stuff_err),
    .dbg_state    (dbg_state),
    .dbg_ones_cnt (dbg_ones_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: apply one cycle of input at negedge, check registered result after posedge
  task automatic step(input bit pkt, input bit v, input bit b);
    bit exp_valid, exp_drop;
    logic exp_b;
    logic [31:0] exp_state;
    pkt_start = pkt;
    in_valid  = v;
    in_bit    = b;
    exp_valid = 0;
    exp_drop  = 0;
    if (pkt) begin
      m_run = 0;
      m_err = 0;
    end
    if (v && !m_err) begin
      if (m_run == MAX) begin
        if (!b) begin
          exp_drop = 1;
          m_run = 0;
        end else begin
          m_err = 1;
        end
      end else begin
        exp_valid = 1;
        exp_q.push_back(b);
        m_run = b ? m_run + 1 : 0;
      end
    end
    exp_state = m_err ? 32'(ERROR) : (m_run == MAX) ? 32'(EXPECT_STUFF) : 32'(NORMAL);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("stuff_drop", 32'(stuff_drop), 32'(exp_drop));
    check("stuff_err", 32'(stuff_err), 32'(m_err));
    check("ones_cnt", 32'(dbg_ones_cnt), 32'(m_run));
    check("state", 32'(dbg_state), exp_state);
    if (out_valid) begin
      seg_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_bit), 32'hDEAD);
      end else begin
        exp_b = exp_q.pop_front();
        check("out_bit", 32'(out_bit), 32'(exp_b));
      end
    end
    if (stuff_drop) seg_drop++;
    exp_q.delete();
    @(negedge clk);
    pkt_start = 0;
    in_valid  = 0;
    in_bit    = 0;
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1);
  endtask

  task automatic new_seg();
    step(1, 0, 0);
    seg_valid = 0;
    seg_drop  = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_bit"}, 32'(out_bit), 0);
    check({tag, "_drop"}, 32'(stuff_drop), 0);
    check({tag, "_err"}, 32'(stuff_err), 0);
    check({tag, "_cnt"}, 32'(dbg_ones_cnt), 0);
  endtask

  initial begin
    bit pat[5];
    pat = '{1, 0, 1, 1, 0};
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_state", 32'(dbg_state), 32'(NORMAL));
    nRST = 1'b1;
    @(negedge clk);

    // 1: plain data
    new_seg();
    for (int i = 0; i < 5; i++) step(0, 1, pat[i]);
    check("t1_count", 32'(seg_valid), 5);
    check("t1_drops", 32'(seg_drop), 0);

    // 2: six 1s, stuffed 0, then 1
    new_seg();
    ones(6);
    step(0, 1, 0);
    step(0, 1, 1);
    check("t2_count", 32'(seg_valid), 7);
    check("t2_drops", 32'(seg_drop), 1);

    // 3: seven 1s -> error, then bits ignored, then pkt_start clears
    new_seg();
    ones(7);
    step(0, 1, 0);
    step(0, 1, 1);
    check("t3_count", 32'(seg_valid), 6);
    check("t3_err", 32'(stuff_err), 1);
    step(1, 0, 0);
    check("t3_clear", 32'(stuff_err), 0);

    // 4: gaps do not break a run
    new_seg();
    ones(5);
    repeat (3) step(0, 0, 1);
    step(0, 1, 1);
    step(0, 1, 0);
    check("t4_count", 32'(seg_valid), 6);
    check("t4_drops", 32'(seg_drop), 1);

    // 5: pkt_start while expecting a stuff bit, with a 1 in the same cycle
    new_seg();
    ones(6);
    step(1, 1, 1);
    check("t5_err", 32'(stuff_err), 0);
    check("t5_cnt", 32'(dbg_ones_cnt), 1);
    check("t5_valid", 32'(out_valid), 1);

    // 6: async reset mid-packet
    new_seg();
    ones(4);
    #2 nRST = 1'b0;
    #1 check_outputs_zero("t6_rst");
    @(negedge clk);
    check_outputs_zero("t6_hold");
    nRST = 1'b1;
    m_run = 0;
    m_err = 0;
    seg_valid = 0;
    seg_drop = 0;
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 0);
    check("t6_count", 32'(seg_valid), 3);
    check("t6_drops", 32'(seg_drop), 0);

    // random traffic, biased toward long runs of 1s
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85,
           $urandom_range(0, 9) < 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
